// File: rtl/gerador_eventos_lampada.sv
// -----------------------------------------------------------------------------
// gerador_eventos_lampada
//
// Event generator and timing controller for the automatic-lighting lamp FSM.
// Synchronizes the raw push-button and infrared inputs, debounces the button,
// measures press duration and runs the inactivity timer. It produces the lamp
// FSM condition inputs: one-cycle events a/b/c and the presence level d.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous, active-high reset
//   botao        in   raw push-button (1 = pressed), asynchronous to clk
//   infra        in   raw infrared presence sensor (1 = presence), asynchronous
//   enable_sub_3 in   lamp-on-automatic indication, enables inactivity timer
//   a            out  one-cycle pulse: press held for T_LONG_MS
//   b            out  one-cycle pulse: release with T_SHORT_MS < dur < T_LONG_MS
//   c            out  one-cycle pulse: inactivity reached T_INACT_MS
//   d            out  level: synchronized infra (2-cycle latency)
// -----------------------------------------------------------------------------
module gerador_eventos_lampada #(
    parameter int TICKS_PER_MS = 1000,
    parameter int DEB_MS       = 20,
    parameter int T_SHORT_MS   = 300,
    parameter int T_LONG_MS    = 5000,
    parameter int T_INACT_MS   = 30000
) (
    input  logic clk,
    input  logic rst,
    input  logic botao,
    input  logic infra,
    input  logic enable_sub_3,
    output logic a,
    output logic b,
    output logic c,
    output logic d
);

    // A prescaler for TICKS_PER_MS = 1 would otherwise get a zero-width counter.
    localparam int PRE_W   = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam int DEB_W   = $clog2(DEB_MS + 1);
    localparam int PRESS_W = $clog2(T_LONG_MS + 1);
    localparam int INACT_W = $clog2(T_INACT_MS + 1);

    localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(TICKS_PER_MS - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEB_MS - 1);
    localparam logic [PRESS_W-1:0] SHORT_C    = PRESS_W'(T_SHORT_MS);
    localparam logic [PRESS_W-1:0] LONG_C     = PRESS_W'(T_LONG_MS);
    localparam logic [PRESS_W-1:0] LONG_LAST  = PRESS_W'(T_LONG_MS - 1);
    localparam logic [INACT_W-1:0] INACT_LAST = INACT_W'(T_INACT_MS - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESSED      = 2'd1,
        WAIT_RELEASE = 2'd2
    } press_state_t;

    logic               botao_meta_r;
    logic               botao_sync_r;
    logic               infra_meta_r;
    logic               infra_sync_r;
    logic [PRE_W-1:0]   pre_r;
    logic               ms_tick_s;
    logic [DEB_W-1:0]   deb_cnt_r;
    logic               deb_level_r;
    logic               deb_prev_r;
    logic               deb_rise_s;
    logic               deb_fall_s;
    press_state_t       state_r;
    press_state_t       state_next_s;
    logic [PRESS_W-1:0] press_cnt_r;
    logic [PRESS_W-1:0] press_cnt_next_s;
    logic               a_next_s;
    logic               b_next_s;
    logic               a_r;
    logic               b_r;
    logic [INACT_W-1:0] inact_cnt_r;
    logic               c_r;

    // Two-flop synchronizers for both asynchronous inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            botao_meta_r <= 1'b0;
            botao_sync_r <= 1'b0;
            infra_meta_r <= 1'b0;
            infra_sync_r <= 1'b0;
        end else begin
            botao_meta_r <= botao;
            botao_sync_r <= botao_meta_r;
            infra_meta_r <= infra;
            infra_sync_r <= infra_meta_r;
        end
    end

    assign ms_tick_s = (pre_r == PRE_LAST);

    // Free-running 1 ms prescaler; ms_tick_s marks its last count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_r <= {PRE_W{1'b0}};
        end else if (ms_tick_s) begin
            pre_r <= {PRE_W{1'b0}};
        end else begin
            pre_r <= pre_r + PRE_W'(1);
        end
    end

    // Debouncer: level flips after DEB_MS consecutive differing ms samples;
    // any agreeing cycle restarts the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_cnt_r   <= {DEB_W{1'b0}};
            deb_level_r <= 1'b0;
            deb_prev_r  <= 1'b0;
        end else begin
            deb_prev_r <= deb_level_r;
            if (botao_sync_r == deb_level_r) begin
                deb_cnt_r <= {DEB_W{1'b0}};
            end else if (ms_tick_s) begin
                if (deb_cnt_r == DEB_LAST) begin
                    deb_level_r <= ~deb_level_r;
                    deb_cnt_r   <= {DEB_W{1'b0}};
                end else begin
                    deb_cnt_r <= deb_cnt_r + DEB_W'(1);
                end
            end else begin
                deb_cnt_r <= deb_cnt_r;
            end
        end
    end

    assign deb_rise_s = deb_level_r & ~deb_prev_r;
    assign deb_fall_s = ~deb_level_r & deb_prev_r;

    // Press FSM state, press counter and registered a/b pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            press_cnt_r <= {PRESS_W{1'b0}};
            a_r         <= 1'b0;
            b_r         <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            press_cnt_r <= press_cnt_next_s;
            a_r         <= a_next_s;
            b_r         <= b_next_s;
        end
    end

    // Press FSM next state. A release takes priority over reaching the long
    // threshold in the same cycle, so a and b can never both fire.
    always_comb begin
        state_next_s     = state_r;
        press_cnt_next_s = press_cnt_r;
        a_next_s         = 1'b0;
        b_next_s         = 1'b0;
        case (state_r)
            IDLE: begin
                if (deb_rise_s) begin
                    state_next_s     = PRESSED;
                    press_cnt_next_s = {PRESS_W{1'b0}};
                end else begin
                    state_next_s = IDLE;
                end
            end
            PRESSED: begin
                if (deb_fall_s) begin
                    state_next_s = IDLE;
                    b_next_s     = (press_cnt_r > SHORT_C);
                end else if (ms_tick_s) begin
                    if (press_cnt_r == LONG_LAST) begin
                        // Counter saturates at T_LONG_MS.
                        press_cnt_next_s = LONG_C;
                        a_next_s         = 1'b1;
                        state_next_s     = WAIT_RELEASE;
                    end else begin
                        press_cnt_next_s = press_cnt_r + PRESS_W'(1);
                    end
                end else begin
                    state_next_s = PRESSED;
                end
            end
            WAIT_RELEASE: begin
                if (deb_fall_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = WAIT_RELEASE;
                end
            end
            default: begin
                state_next_s     = IDLE;
                press_cnt_next_s = {PRESS_W{1'b0}};
            end
        endcase
    end

    // Inactivity timer: counts ms while enabled with no presence, pulses c
    // and restarts at T_INACT_MS so c repeats while conditions persist.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inact_cnt_r <= {INACT_W{1'b0}};
            c_r         <= 1'b0;
        end else if (!enable_sub_3 || infra_sync_r) begin
            inact_cnt_r <= {INACT_W{1'b0}};
            c_r         <= 1'b0;
        end else if (ms_tick_s) begin
            if (inact_cnt_r == INACT_LAST) begin
                inact_cnt_r <= {INACT_W{1'b0}};
                c_r         <= 1'b1;
            end else begin
                inact_cnt_r <= inact_cnt_r + INACT_W'(1);
                c_r         <= 1'b0;
            end
        end else begin
            c_r <= 1'b0;
        end
    end

    assign a = a_r;
    assign b = b_r;
    assign c = c_r;
    assign d = infra_sync_r;

endmodule

// File: tb/tb_gerador_eventos_lampada.sv
// -----------------------------------------------------------------------------
// Testbench for gerador_eventos_lampada. Runs with a scaled time base
// (2 clk per ms, shortened thresholds) so every scenario stays short.
// -----------------------------------------------------------------------------
module tb_gerador_eventos_lampada;

    localparam int TPM = 2;
    localparam int DEB = 10;
    localparam int TS  = 50;
    localparam int TL  = 250;
    localparam int TI  = 1500;

    logic clk = 1'b0;
    logic rst;
    logic botao;
    logic infra;
    logic enable_sub_3;
    logic a, b, c, d;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int a_q[$];
    int b_q[$];
    int c_q[$];

    gerador_eventos_lampada #(
        .TICKS_PER_MS(TPM),
        .DEB_MS      (DEB),
        .T_SHORT_MS  (TS),
        .T_LONG_MS   (TL),
        .T_INACT_MS  (TI)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .botao       (botao),
        .infra       (infra),
        .enable_sub_3(enable_sub_3),
        .a           (a),
        .b           (b),
        .c           (c),
        .d           (d)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event logger plus the "a and b never together" check.
    always @(negedge clk) begin
        if (a) a_q.push_back(cyc);
        if (b) b_q.push_back(cyc);
        if (c) c_q.push_back(cyc);
        if (a || b) begin
            n_cmp++;
            if (a && b) begin
                n_bad++;
                $display("FAIL a_b_exclusive: got a=%0b b=%0b at cycle %0d, want not both", a, b, cyc);
            end
        end
    end

    task automatic check_eq(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        a_q.delete();
        b_q.delete();
        c_q.delete();
    endtask

    task automatic check_outs_zero(input string tag);
        check_eq({tag, " a"}, int'(a), 0);
        check_eq({tag, " b"}, int'(b), 0);
        check_eq({tag, " c"}, int'(c), 0);
        check_eq({tag, " d"}, int'(d), 0);
    endtask

    // Reference rule: classify a press by its held duration in ms.
    function automatic void model_press(input int hold_cyc, output int ea, output int eb);
        int ms;
        ms = hold_cyc / TPM;
        ea = 0;
        eb = 0;
        if (ms >= DEB) begin
            if (ms >= TL) ea = 1;
            else if (ms > TS) eb = 1;
        end
    endfunction

    // Apply one press of hold_cyc cycles followed by gap_cyc released cycles
    // and check the resulting events against expectations.
    task automatic do_press(input string tag, input int hold_cyc, input int gap_cyc,
                            input int ea, input int eb);
        int t0;
        int t1;
        clear_log();
        t0 = cyc;
        botao = 1'b1;
        wait_cyc(hold_cyc);
        t1 = cyc;
        botao = 1'b0;
        wait_cyc(gap_cyc);
        check_eq({tag, " a count"}, a_q.size(), ea);
        check_eq({tag, " b count"}, b_q.size(), eb);
        check_eq({tag, " c count"}, c_q.size(), 0);
        if (ea == 1 && a_q.size() == 1) check_rng({tag, " a latency"}, a_q[0] - t0, 505, 545);
        if (eb == 1 && b_q.size() == 1) check_rng({tag, " b latency"}, b_q[0] - t1, 12, 40);
    endtask

    typedef struct {
        int hold;
        int exp_a;
        int exp_b;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int t0;
        int tf;
        int ea;
        int eb;
        int hold;
        int cls;

        tbl[0] = '{300, 0, 1};   // medium press
        tbl[1] = '{60,  0, 0};   // short press
        tbl[2] = '{10,  0, 0};   // glitch
        tbl[3] = '{800, 1, 0};   // long press, no b on release
        tbl[4] = '{150, 0, 1};
        tbl[5] = '{480, 0, 1};   // just below long
        tbl[6] = '{120, 0, 1};   // just above short
        tbl[7] = '{85,  0, 0};   // just below short
        tbl[8] = '{15,  0, 0};   // glitch near debounce window
        tbl[9] = '{600, 1, 0};

        rst = 1'b1;
        botao = 1'b0;
        infra = 1'b0;
        enable_sub_3 = 1'b0;
        wait_cyc(3);
        check_outs_zero("in_reset");
        rst = 1'b0;
        wait_cyc(2);
        check_outs_zero("after_reset");
        wait_cyc(40);

        // Table-driven press classification.
        for (int i = 0; i < 10; i++) begin
            do_press($sformatf("tbl%0d", i), tbl[i].hold, 80, tbl[i].exp_a, tbl[i].exp_b);
        end

        // Randomized presses against the duration rule.
        for (int i = 0; i < 12; i++) begin
            cls = $urandom_range(0, 3);
            case (cls)
                0: hold = $urandom_range(1, 14);
                1: hold = $urandom_range(30, 85);
                2: hold = $urandom_range(120, 470);
                default: hold = $urandom_range(540, 750);
            endcase
            model_press(hold, ea, eb);
            do_press($sformatf("rnd%0d_h%0d", i, hold), hold, $urandom_range(60, 200), ea, eb);
        end

        // Inactivity timeout repeats every T_INACT while no presence.
        clear_log();
        t0 = cyc;
        enable_sub_3 = 1'b1;
        wait_cyc(6100);
        check_eq("inact c count", c_q.size(), 2);
        if (c_q.size() >= 1) check_rng("inact first c", c_q[0] - t0, 2990, 3010);
        if (c_q.size() == 2) check_eq("inact c period", c_q[1] - c_q[0], TI * TPM);
        check_eq("inact a count", a_q.size(), 0);
        check_eq("inact b count", b_q.size(), 0);
        enable_sub_3 = 1'b0;
        wait_cyc(5);

        // Presence restarts the timer; d follows infra with 2-cycle lag.
        clear_log();
        enable_sub_3 = 1'b1;
        wait_cyc(2000);
        infra = 1'b1;
        wait_cyc(1);
        check_eq("d lag 1 cycle", int'(d), 0);
        wait_cyc(1);
        check_eq("d lag 2 cycles", int'(d), 1);
        wait_cyc(98);
        tf = cyc;
        infra = 1'b0;
        wait_cyc(2);
        check_eq("d fall", int'(d), 0);
        wait_cyc(3098);
        check_eq("presence c count", c_q.size(), 1);
        if (c_q.size() >= 1) check_rng("presence c after fall", c_q[0] - tf, 2990, 3015);
        enable_sub_3 = 1'b0;
        wait_cyc(5);

        // Dropping the enable just before timeout restarts the count.
        clear_log();
        enable_sub_3 = 1'b1;
        wait_cyc(2900);
        enable_sub_3 = 1'b0;
        wait_cyc(50);
        check_eq("enable drop c count", c_q.size(), 0);
        t0 = cyc;
        enable_sub_3 = 1'b1;
        wait_cyc(3050);
        check_eq("enable resume c count", c_q.size(), 1);
        if (c_q.size() >= 1) check_rng("enable resume c", c_q[0] - t0, 2990, 3010);
        enable_sub_3 = 1'b0;
        wait_cyc(5);

        // Reset mid-timeout discards the accumulated count.
        clear_log();
        enable_sub_3 = 1'b1;
        wait_cyc(2500);
        rst = 1'b1;
        wait_cyc(3);
        rst = 1'b0;
        t0 = cyc;
        wait_cyc(1000);
        check_eq("reset timeout c count", c_q.size(), 0);
        wait_cyc(2100);
        check_eq("post reset c count", c_q.size(), 1);
        if (c_q.size() >= 1) check_rng("post reset c", c_q[0] - t0, 2990, 3010);
        enable_sub_3 = 1'b0;
        wait_cyc(5);

        // Reset mid-press with the button still held at release.
        clear_log();
        infra = 1'b1;
        botao = 1'b1;
        wait_cyc(300);
        rst = 1'b1;
        wait_cyc(1);
        check_outs_zero("press reset");
        wait_cyc(2);
        infra = 1'b0;
        clear_log();
        rst = 1'b0;
        t0 = cyc;
        wait_cyc(700);
        check_eq("held reset a count", a_q.size(), 1);
        if (a_q.size() >= 1) check_rng("held reset a latency", a_q[0] - t0, 505, 545);
        botao = 1'b0;
        wait_cyc(80);
        check_eq("held reset b count", b_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gerador_eventos_lampada.md
Name: gerador_eventos_lampada

Overview:
Event generator and timing controller that drives the automatic-lighting lamp FSM's condition inputs a, b, c and d. It synchronizes and debounces the raw push-button and infrared inputs, measures press duration, and runs the 30 s inactivity timer. It also turns these into single-cycle event pulses and a presence level. It sits between the board I/O and the lamp FSM and consumes that FSM's enable_sub_3 as the inactivity-timer enable.

Parameters:
TICKS_PER_MS, 1000, clk cycles per 1 ms time base (1 MHz clk).
DEB_MS, 20, button debounce window in ms.
T_SHORT_MS, 300, lower press-duration bound (exclusive) for a short press.
T_LONG_MS, 5000, press duration (inclusive) for a long press.
T_INACT_MS, 30000, inactivity timeout in ms.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
botao  in  1  raw push-button, 1 = pressed, asynchronous to clk.
infra  in  1  raw infrared presence sensor, 1 = presence, asynchronous to clk.
enable_sub_3  in  1  lamp-on-automatic indication from the lamp FSM; enables the inactivity timer.
a  out  1  one-cycle pulse: press held >= T_LONG_MS.
b  out  1  one-cycle pulse: press released with T_SHORT_MS < duration < T_LONG_MS.
c  out  1  one-cycle pulse: inactivity reached T_INACT_MS.
d  out  1  level: synchronized infra.

Behaviour:
- Reset: all outputs 0. Prescaler, debounce counter, press counter and inactivity counter go to 0. Synchronizer flops go to 0. Debounced button level goes to 0 (released). Press FSM goes to IDLE.
- Synchronizers: botao and infra each pass through 2 flops. d = infra sync output, so d lags infra by 2 clk cycles. No debounce on infra.
- Time base: free-running prescaler 0..TICKS_PER_MS-1. ms_tick is a 1-cycle pulse when the prescaler wraps. All ms counters advance only on ms_tick, so resolution is ±1 ms.
- Debouncer: the debounced level changes only after the synchronized button differs from it for DEB_MS consecutive ms_ticks. Any sample equal to the current level clears the debounce counter.
- Press FSM states: IDLE, PRESSED, WAIT_RELEASE.
  - IDLE -> PRESSED on debounced rising edge; press counter cleared to 0.
  - PRESSED: press counter increments on ms_tick.
    - When the counter reaches T_LONG_MS, assert a for 1 cycle and go to WAIT_RELEASE.
    - On debounced falling edge before that, go to IDLE. Assert b for 1 cycle only if counter > T_SHORT_MS; otherwise emit no event.
  - WAIT_RELEASE -> IDLE on debounced falling edge; no event.
- a and b are never asserted in the same cycle. At most one event is produced per press.
- Inactivity timer:
  - Counts ms_ticks while enable_sub_3 = 1 and d = 0.
  - Cleared to 0 in any cycle where enable_sub_3 = 0 or d = 1.
  - On reaching T_INACT_MS, assert c for 1 cycle and clear the counter to 0.
  - If enable_sub_3 stays 1 with no presence, c repeats every T_INACT_MS.
- Simultaneous events: c may coincide with a, b or d = 1. No suppression is applied here; the lamp FSM's priority resolves it.
- Button held across reset release: treated as a fresh press starting DEB_MS after reset deassertion.
- Reset mid-press or mid-timeout: all state is discarded and no pending pulse is emitted.
- Counter widths: each is sized with $clog2 of its maximum value + 1 and must not overflow. The press counter stops at T_LONG_MS.

Test Plan:
1. Override TICKS_PER_MS=1, DEB_MS=20. Press for 1000 cycles, then release -> exactly one b pulse, roughly 20 cycles after the release; a and c stay 0.
2. Press for 200 cycles, then release -> no a and no b. Repeat with a 10-cycle glitch press -> debouncer rejects it; no event.
3. Hold the press for 8000 cycles -> a pulses once about 5020 cycles after the press; no b on release; the FSM is back in IDLE afterwards.
4. enable_sub_3=1, infra=0 for 60000 cycles -> c pulses at about 30000 and about 60000. Raise infra at 20000 -> d=1 two cycles later, counter clears, and c arrives about 30000 cycles after infra falls.
5. Drop enable_sub_3 to 0 at 29000 -> no c; the timeout restarts from 0 when enable_sub_3 returns to 1.
6. Assert rst at 3000 cycles into a held press -> all outputs 0. Button still held at reset release -> a arrives about 5020 cycles after reset deassertion.
